// File: rtl/ram_bank_ctrl.sv
// ram_bank_ctrl: NBANKS independent single-port synchronous RAM banks on the
// 7800 bus, one-hot bank selects, registered read-data select, sticky
// select-error flag. Define RAM_CLEAR_EN to include the clear sequencer that
// zero-fills every bank while a cartridge is loading; without it the banks
// power up zeroed and loading is ignored.
module ram_bank_ctrl #(
    parameter int unsigned NBANKS = 2,
    parameter int unsigned AW     = 11,
    parameter int unsigned DW     = 8,
    parameter logic [31:0] FILL   = 32'h46
) (
    input  logic              memclk,
    input  logic              reset,
    input  logic              loading,
    input  logic [NBANKS-1:0] bank_sel,
    input  logic [AW-1:0]     addr,
    input  logic [DW-1:0]     wdata,
    input  logic              rw,
    output logic [DW-1:0]     rdata,
    output logic              clear_busy,
    output logic              clear_done,
    output logic              sel_err
);

    localparam int unsigned   DEPTH     = 1 << AW;
    localparam logic [DW-1:0] FILL_DW   = DW'(FILL);
    localparam logic [AW-1:0] LAST_ADDR = '1;

    logic              multi_hot;
    logic              clearing;
    logic [AW-1:0]     clr_addr;
    logic [NBANKS-1:0] sel_q;
    logic              sel_q_onehot;
    logic [DW-1:0]     q [NBANKS];

    // More than one select bit high: clearing the lowest set bit leaves something.
    assign multi_hot    = |(bank_sel & (bank_sel - NBANKS'(1)));
    assign sel_q_onehot = (sel_q != '0) && ((sel_q & (sel_q - NBANKS'(1))) == '0);

`ifdef RAM_CLEAR_EN
    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        HOLD
    } clr_state_t;

    clr_state_t    state;
    logic [AW-1:0] cnt;

    // Clear sequencer: one zero write per cycle across all banks, then wait
    // for loading to drop so a single request never clears twice.
    always_ff @(posedge memclk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            clear_busy <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            clear_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (loading) begin
                        state      <= CLEAR;
                        cnt        <= '0;
                        clear_busy <= 1'b1;
                    end
                end
                CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_ADDR) begin
                        clear_busy <= 1'b0;
                        clear_done <= 1'b1;
                        state      <= loading ? HOLD : IDLE;
                    end
                end
                HOLD: begin
                    if (!loading) state <= IDLE;
                end
                default: begin
                    state      <= IDLE;
                    clear_busy <= 1'b0;
                end
            endcase
        end
    end

    assign clearing = (state == CLEAR);
    assign clr_addr = cnt;
`else
    logic unused_loading;

    assign unused_loading = loading;
    assign clearing       = 1'b0;
    assign clr_addr       = '0;
    assign clear_busy     = 1'b0;
    assign clear_done     = 1'b0;
`endif

    // Select pipeline and sticky multi-select error; selects are masked while
    // clearing so the bus sees FILL.
    always_ff @(posedge memclk or posedge reset) begin
        if (reset) begin
            sel_q   <= '0;
            sel_err <= 1'b0;
        end else begin
            sel_q <= clearing ? '0 : bank_sel;
            if (multi_hot) sel_err <= 1'b1;
        end
    end

    for (genvar i = 0; i < NBANKS; i++) begin : g_bank
`ifdef RAM_CLEAR_EN
        logic [DW-1:0] mem [DEPTH];
`else
        logic [DW-1:0] mem [DEPTH] = '{default: '0};
`endif
        logic bus_we;

        assign bus_we = bank_sel[i] && !rw && !multi_hot && !clearing;

        // RAM write port (clear has priority) and registered read of the selected bank.
        // NOTE: the array and q have no reset on purpose: a reset on a RAM
        // prevents block-RAM inference, and contents must survive reset anyway.
        always_ff @(posedge memclk) begin
            if (clearing) begin
                mem[clr_addr] <= '0;
            end else if (bus_we) begin
                mem[addr] <= wdata;
            end
            if (bank_sel[i]) q[i] <= mem[addr];
        end
    end

    // Read-data select: the single bank selected last cycle, otherwise FILL.
    always_comb begin
        // NOTE: assigning the default first in a combinational block means
        // every path drives rdata, so no latch is inferred.
        rdata = FILL_DW;
        for (int i = 0; i < NBANKS; i++) begin
            if (sel_q_onehot && sel_q[i]) rdata = q[i];
        end
    end

endmodule
